// File: rtl/channel_decimator_pkg.sv
// rtl/channel_decimator_pkg.sv - shared defaults, types and width helper for the channel decimator
//
// Purpose : default sample/channel widths, sample and channel typedefs, and the
//           accumulator width helper used by the decimator and its channel bank.
// Ports   : none (package).
package decim_pkg;

  localparam int DEF_DATA_W = 24;
  localparam int DEF_CH_W   = 3;

  typedef logic signed [DEF_DATA_W-1:0] sample_t;
  typedef logic        [DEF_CH_W-1:0]   chan_t;

  // A window of 2^decim_log2 samples needs decim_log2 guard bits above the
  // sample width, so the running sum can never wrap.
  function automatic int acc_width(input int decim_log2, input int data_w = DEF_DATA_W);
    return data_w + decim_log2;
  endfunction

endpackage

// File: rtl/channel_decimator_if.sv
// rtl/channel_decimator_if.sv - stream bundle (tdata/tuser/tlast/tvalid/tready) for the decimator
//
// Purpose : one AXI-Stream style link carrying a signed sample, its channel
//           index and a frame-end marker.
// Ports   : none; modports
//           master - drives tdata, tuser, tlast, tvalid; samples tready
//           slave  - samples tdata, tuser, tlast, tvalid; drives tready
interface channel_decimator_if #(
  parameter int DATA_W = 24,
  parameter int CH_W   = 3
) ();

  logic signed [DATA_W-1:0] tdata;
  logic [CH_W-1:0]          tuser;
  logic                     tlast;
  logic                     tvalid;
  logic                     tready;

  modport master (output tdata, output tuser, output tlast, output tvalid, input tready);
  modport slave  (input tdata, input tuser, input tlast, input tvalid, output tready);

endinterface

// File: rtl/channel_decimator_chan_bank.sv
// rtl/channel_decimator_chan_bank.sv - per-channel accumulator/counter/sticky-last register file
//
// Purpose : holds acc, cnt and lst for every channel; one combinational read
//           port and one synchronous write port, both indexed by channel.
// Ports   : clk, rst             - clock, asynchronous active-high reset
//           rd_idx               - channel to read
//           rd_acc/rd_cnt/rd_lst - state of channel rd_idx (combinational)
//           wr_en, wr_idx        - write strobe and channel
//           wr_acc/wr_cnt/wr_lst - new state for channel wr_idx
module decim_chan_bank
  import decim_pkg::*;
#(
  parameter int DECIM_LOG2 = 4,
  parameter int CH_W       = DEF_CH_W,
  parameter int DATA_W     = DEF_DATA_W,
  localparam int ACC_W     = acc_width(DECIM_LOG2, DATA_W),
  localparam int CNT_W     = (DECIM_LOG2 > 0) ? DECIM_LOG2 : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [CH_W-1:0]         rd_idx,
  output logic signed [ACC_W-1:0] rd_acc,
  output logic [CNT_W-1:0]        rd_cnt,
  output logic                    rd_lst,
  input  logic                    wr_en,
  input  logic [CH_W-1:0]         wr_idx,
  input  logic signed [ACC_W-1:0] wr_acc,
  input  logic [CNT_W-1:0]        wr_cnt,
  input  logic                    wr_lst
);

  localparam int NCH = 1 << CH_W;

  logic signed [ACC_W-1:0] acc [NCH];
  logic [CNT_W-1:0]        cnt [NCH];
  logic                    lst [NCH];

  assign rd_acc = acc[rd_idx];
  assign rd_cnt = cnt[rd_idx];
  assign rd_lst = lst[rd_idx];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        acc[i] <= '0;
        cnt[i] <= '0;
        lst[i] <= 1'b0;
      end
    end else if (wr_en) begin
      acc[wr_idx] <= wr_acc;
      cnt[wr_idx] <= wr_cnt;
      lst[wr_idx] <= wr_lst;
    end
  end

endmodule

// File: rtl/channel_decimator.sv
// rtl/channel_decimator.sv - multi-channel accumulate-and-dump decimator (window mean per channel)
//
// Purpose : sums 2^DECIM_LOG2 consecutive samples per channel (channel given by
//           tuser) and emits their mean on a one-entry output register.
//           DECIM_LOG2 = 0 passes samples through unchanged.
//           Build macro DECIM_ROUND_EN: round half up instead of truncating.
// Ports   : s_axis_aclk - clock
//           s_axis_arst - asynchronous active-high reset
//           s_axis      - input stream  (slave):  tdata sample, tuser channel, tlast frame end
//           m_axis      - output stream (master): tdata window mean, tuser channel,
//                         tlast set if any sample of the window carried tlast
module channel_decimator
  import decim_pkg::*;
#(
  parameter int DECIM_LOG2 = 4,
  parameter int CH_W       = DEF_CH_W,
  parameter int DATA_W     = DEF_DATA_W
) (
  input  logic                 s_axis_aclk,
  input  logic                 s_axis_arst,
  channel_decimator_if.slave   s_axis,
  channel_decimator_if.master  m_axis
);

  localparam int ACC_W = acc_width(DECIM_LOG2, DATA_W);
  localparam int CNT_W = (DECIM_LOG2 > 0) ? DECIM_LOG2 : 1;
  localparam int N     = 1 << DECIM_LOG2;

`ifdef DECIM_ROUND_EN
  // Half an LSB of the mean; zero when DECIM_LOG2 = 0 so pass-through is exact.
  localparam logic signed [ACC_W-1:0] ROUND_BIAS = ACC_W'((1 << DECIM_LOG2) >> 1);
`else
  localparam logic signed [ACC_W-1:0] ROUND_BIAS = '0;
`endif

  logic signed [ACC_W-1:0]  rd_acc;
  logic [CNT_W-1:0]         rd_cnt;
  logic                     rd_lst;
  logic                     wr_en;
  logic signed [ACC_W-1:0]  wr_acc;
  logic [CNT_W-1:0]         wr_cnt;
  logic                     wr_lst;

  logic                     s_ready;
  logic                     accept;
  logic                     complete;
  logic signed [ACC_W-1:0]  x_ext;
  logic signed [ACC_W-1:0]  sum;
  logic signed [ACC_W-1:0]  biased;
  logic signed [DATA_W-1:0] mean;
  logic                     last_any;

  logic signed [DATA_W-1:0] out_data;
  logic [CH_W-1:0]          out_user;
  logic                     out_last;
  logic                     out_valid;

  decim_chan_bank #(
    .DECIM_LOG2 (DECIM_LOG2),
    .CH_W       (CH_W),
    .DATA_W     (DATA_W)
  ) u_bank (
    .clk    (s_axis_aclk),
    .rst    (s_axis_arst),
    .rd_idx (s_axis.tuser),
    .rd_acc (rd_acc),
    .rd_cnt (rd_cnt),
    .rd_lst (rd_lst),
    .wr_en  (wr_en),
    .wr_idx (s_axis.tuser),
    .wr_acc (wr_acc),
    .wr_cnt (wr_cnt),
    .wr_lst (wr_lst)
  );

  // The output register can take a new value whenever it is empty or being
  // drained in this same cycle.
  assign s_ready  = !out_valid || m_axis.tready;
  assign accept   = s_axis.tvalid && s_ready;

  assign x_ext    = ACC_W'(s_axis.tdata);
  assign sum      = rd_acc + x_ext;
  assign last_any = rd_lst || s_axis.tlast;
  assign complete = (rd_cnt == CNT_W'(N - 1));

  // The guard bits keep the biased sum in range, and after the shift the
  // mean is back inside the sample range, so the narrowing cast is lossless.
  assign biased   = sum + ROUND_BIAS;
  assign mean     = DATA_W'(biased >>> DECIM_LOG2);

  always_comb begin
    wr_en  = accept;
    wr_acc = sum;
    wr_cnt = rd_cnt + CNT_W'(1);
    wr_lst = last_any;
    if (complete) begin
      wr_acc = '0;
      wr_cnt = '0;
      wr_lst = 1'b0;
    end
  end

  always_ff @(posedge s_axis_aclk or posedge s_axis_arst) begin
    if (s_axis_arst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_user  <= '0;
      out_last  <= 1'b0;
    end else if (accept && complete) begin
      out_valid <= 1'b1;
      out_data  <= mean;
      out_user  <= s_axis.tuser;
      out_last  <= last_any;
    end else if (m_axis.tready) begin
      out_valid <= 1'b0;
    end
  end

  assign s_axis.tready = s_ready;
  assign m_axis.tvalid = out_valid;
  assign m_axis.tdata  = out_data;
  assign m_axis.tuser  = out_user;
  assign m_axis.tlast  = out_last;

endmodule

// File: tb/tb_channel_decimator.sv
// tb/tb_channel_decimator.sv - self-checking bench for channel_decimator (DECIM_LOG2 = 2)
module tb_channel_decimator;

  localparam int DL = 2;
  localparam int CW = 3;
  localparam int DW = 24;
  localparam int N  = 1 << DL;
  localparam int NCH = 1 << CW;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  channel_decimator_if #(.DATA_W(DW), .CH_W(CW)) s_if ();
  channel_decimator_if #(.DATA_W(DW), .CH_W(CW)) m_if ();

  channel_decimator #(.DECIM_LOG2(DL), .CH_W(CW), .DATA_W(DW)) dut (
    .s_axis_aclk (clk),
    .s_axis_arst (rst),
    .s_axis      (s_if),
    .m_axis      (m_if)
  );

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Reference model: per-channel list of pending sample values and a tlast flag;
  // when a channel has N samples its window mean (floor or round half up) is queued.
  longint win_sum [NCH];
  int     win_cnt [NCH];
  bit     win_lst [NCH];
  longint exp_data [$];
  int     exp_user [$];
  bit     exp_last [$];

  function automatic longint window_mean(input longint s);
    longint v;
    v = s;
`ifdef DECIM_ROUND_EN
    v = v + N / 2;
`endif
    if (v >= 0) return v / N;
    return -((-v + N - 1) / N);
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      for (int c = 0; c < NCH; c++) begin
        win_sum[c] = 0;
        win_cnt[c] = 0;
        win_lst[c] = 1'b0;
      end
      exp_data.delete();
      exp_user.delete();
      exp_last.delete();
    end else begin
      chk("s_tready_rule", s_if.tready, (!m_if.tvalid || m_if.tready));
      if (m_if.tvalid && m_if.tready) begin
        if (exp_data.size() == 0) begin
          chk("unexpected_output", 1, 0);
        end else begin
          chk("out_tdata", longint'(m_if.tdata), exp_data.pop_front());
          chk("out_tuser", m_if.tuser, exp_user.pop_front());
          chk("out_tlast", m_if.tlast, exp_last.pop_front());
        end
      end
      if (s_if.tvalid && s_if.tready) begin
        int c;
        c = int'(s_if.tuser);
        win_sum[c] += longint'(s_if.tdata);
        win_lst[c] |= s_if.tlast;
        win_cnt[c]++;
        if (win_cnt[c] == N) begin
          exp_data.push_back(window_mean(win_sum[c]));
          exp_user.push_back(c);
          exp_last.push_back(win_lst[c]);
          win_sum[c] = 0;
          win_cnt[c] = 0;
          win_lst[c] = 1'b0;
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the sample was accepted.
  task automatic send(input int ch, input longint d, input bit l);
    int k;
    s_if.tuser  = CW'(ch);
    s_if.tdata  = DW'(d);
    s_if.tlast  = l;
    s_if.tvalid = 1'b1;
    k = 0;
    @(negedge clk);
    while (!s_if.tready && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (k >= 50) chk("send_timeout", 0, 1);
    @(posedge clk);
    #1;
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
  endtask

  initial begin
    longint exp_rnd;
    rst = 1'b1;
    s_if.tvalid = 1'b0;
    s_if.tdata  = '0;
    s_if.tuser  = '0;
    s_if.tlast  = 1'b0;
    m_if.tready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tvalid", m_if.tvalid, 0);
    chk("rst_tdata", longint'(m_if.tdata), 0);
    chk("rst_tuser", m_if.tuser, 0);
    chk("rst_tlast", m_if.tlast, 0);
    chk("rst_s_tready", s_if.tready, 1);
    rst = 1'b0;

    // 1,2,3,6 on channel 0 -> 3
    send(0, 1, 0); send(0, 2, 0); send(0, 3, 0);
    @(negedge clk);
    chk("t1_no_early_out", m_if.tvalid, 0);
    @(posedge clk); #1;
    send(0, 6, 0);
    @(negedge clk);
    chk("t1_tvalid", m_if.tvalid, 1);
    chk("t1_tdata", longint'(m_if.tdata), 3);
    chk("t1_tuser", m_if.tuser, 0);
    chk("t1_tlast", m_if.tlast, 0);
    @(posedge clk); #1;

    // interleaved ch0 = 100, ch5 = -100
    for (int i = 0; i < N - 1; i++) begin
      send(0, 100, 0);
      send(5, -100, 0);
    end
    send(0, 100, 0);
    @(negedge clk);
    chk("t2_ch0_tdata", longint'(m_if.tdata), 100);
    chk("t2_ch0_tuser", m_if.tuser, 0);
    @(posedge clk); #1;
    send(5, -100, 0);
    @(negedge clk);
    chk("t2_ch5_tdata", longint'(m_if.tdata), -100);
    chk("t2_ch5_tuser", m_if.tuser, 5);
    @(posedge clk); #1;

    // -1,-1,-1,-2 on channel 2: sum -5
`ifdef DECIM_ROUND_EN
    exp_rnd = -1;
`else
    exp_rnd = -2;
`endif
    send(2, -1, 0); send(2, -1, 0); send(2, -1, 0); send(2, -2, 0);
    @(negedge clk);
    chk("t3_tdata", longint'(m_if.tdata), exp_rnd);
    @(posedge clk); #1;

    // sticky tlast on channel 1, cleared for the next window
    send(1, 4, 0); send(1, 4, 1); send(1, 4, 0); send(1, 4, 0);
    @(negedge clk);
    chk("t4_tlast_set", m_if.tlast, 1);
    chk("t4_tdata", longint'(m_if.tdata), 4);
    @(posedge clk); #1;
    send(1, 4, 0); send(1, 4, 0); send(1, 4, 0); send(1, 4, 0);
    @(negedge clk);
    chk("t4_tlast_clear", m_if.tlast, 0);
    @(posedge clk); #1;

    // backpressure, then drain and complete in the same cycle
    send(4, 10, 0); send(4, 10, 0); send(4, 10, 0);
    m_if.tready = 1'b0;
    send(3, 8, 0); send(3, 8, 0); send(3, 8, 0); send(3, 8, 0);
    @(negedge clk);
    chk("t5_s_tready_low", s_if.tready, 0);
    chk("t5_held_tdata", longint'(m_if.tdata), 8);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t5_stable_tvalid", m_if.tvalid, 1);
      chk("t5_stable_tdata", longint'(m_if.tdata), 8);
    end
    @(posedge clk); #1;
    m_if.tready = 1'b1;
    send(4, 10, 0);
    @(negedge clk);
    chk("t5_b2b_tvalid", m_if.tvalid, 1);
    chk("t5_b2b_tdata", longint'(m_if.tdata), 10);
    chk("t5_b2b_tuser", m_if.tuser, 4);
    @(posedge clk); #1;

    // reset mid-window with an output pending
    send(6, 5, 0); send(6, 5, 0); send(6, 5, 0);
    m_if.tready = 1'b0;
    send(7, 1, 0); send(7, 1, 0); send(7, 1, 0); send(7, 1, 0);
    @(negedge clk);
    chk("t6_pending", m_if.tvalid, 1);
    #2 rst = 1'b1;
    #1 chk("t6_async_clear", m_if.tvalid, 0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    m_if.tready = 1'b1;
    send(6, 8, 0); send(6, 8, 0); send(6, 8, 0); send(6, 8, 0);
    @(negedge clk);
    chk("t6_tdata", longint'(m_if.tdata), 8);
    chk("t6_tuser", m_if.tuser, 6);
    @(posedge clk); #1;

    // randomized traffic checked by the model
    for (int i = 0; i < 2000; i++) begin
      s_if.tvalid = ($urandom_range(0, 2) != 0);
      s_if.tuser  = CW'($urandom_range(0, NCH - 1));
      s_if.tdata  = DW'($urandom);
      s_if.tlast  = ($urandom_range(0, 7) == 0);
      m_if.tready = ($urandom_range(0, 3) != 0);
      @(posedge clk);
      #1;
    end
    s_if.tvalid = 1'b0;
    m_if.tready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("drain_empty", exp_data.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/channel_decimator.md
Name: channel_decimator

Overview:
- Multi-channel accumulate-and-dump decimator placed directly downstream of the lowpass FIR stage.
- Input is the interleaved 24-bit filtered stream; tuser carries the channel index, 8 channels by default.
- For each channel it sums 2^DECIM_LOG2 consecutive samples and emits their mean as one output sample.
- Output uses the same AXI-Stream format (tdata/tuser/tlast), so the rate reduction is transparent to later stages.

Parameters:
- DECIM_LOG2, 4: log2 of the decimation ratio N; legal range 0..8; 0 = pass-through.
- CH_W, 3: channel index width; 2^CH_W channels.
- DATA_W, 24: sample width, signed.

Ports:
- s_axis_aclk  in  1  clock.
- s_axis_arst  in  1  reset, asynchronous, active-high.
- s_axis_tdata  in  DATA_W  signed filtered sample.
- s_axis_tvalid  in  1  input valid.
- s_axis_tready  out  1  input ready.
- s_axis_tuser  in  CH_W  channel index.
- s_axis_tlast  in  1  frame end marker.
- m_axis_tdata  out  DATA_W  signed decimated sample (window mean).
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  output ready.
- m_axis_tuser  out  CH_W  channel index of the output sample.
- m_axis_tlast  out  1  a tlast was seen anywhere in this window.

Behaviour:
- Reset: one clock; reset is asynchronous and active-high.
  - Asserting s_axis_arst clears all per-channel accumulators, counters and sticky-last flags.
  - It also clears m_axis_tvalid, m_axis_tdata, m_axis_tuser and m_axis_tlast to 0.
  - Reset mid-window discards partial sums; no output is produced for them.
- Per-channel state, indexed by tuser:
  - acc[c], signed, DATA_W+DECIM_LOG2 bits.
  - cnt[c], DECIM_LOG2 bits.
  - lst[c], 1 bit.
- Accept condition: s_axis_tvalid & s_axis_tready.
  - s_axis_tready = !m_axis_tvalid | m_axis_tready (one-entry output register, drained in the same cycle).
- On accept of sample x for channel c:
  - sum = acc[c] + sign-extended x; l = lst[c] | s_axis_tlast.
  - If cnt[c] != N-1: acc[c] <= sum, cnt[c] <= cnt[c]+1, lst[c] <= l. No output.
  - If cnt[c] == N-1 (window complete):
    - m_axis_tdata <= sum >>> DECIM_LOG2 (arithmetic shift, truncation toward −inf).
    - m_axis_tuser <= c; m_axis_tlast <= l; m_axis_tvalid <= 1.
    - acc[c] <= 0, cnt[c] <= 0, lst[c] <= 0.
- Latency: output valid 1 cycle after the accept of the window-completing sample.
- The output register holds its value until m_axis_tvalid & m_axis_tready.
  - Drain and a new completion in the same cycle: the new value is loaded and m_axis_tvalid stays 1.
  - Drain with no new completion: m_axis_tvalid <= 0.
- Channels are independent; arbitrary interleaving order is legal, and so are non-equal per-channel rates.
- DECIM_LOG2 = 0: every accepted sample is output unchanged next cycle, with tuser and tlast passed through.
- Width: the sum never overflows because the accumulator has DECIM_LOG2 guard bits. The mean always fits DATA_W with no saturation needed.
- tvalid with tready low: inputs are ignored; no state changes.

Optional Feature:
- DECIM_ROUND_EN defined (only when DECIM_LOG2 >= 1):
  - Output = (sum + 2^(DECIM_LOG2-1)) >>> DECIM_LOG2, i.e. round half up.
  - Maximum positive case still yields 2^(DATA_W-1)-1, so no overflow.
- Undefined: plain truncating arithmetic shift as above.

Decomposition:
- Package decim_pkg:
  - DATA_W and CH_W defaults.
  - typedef sample_t (signed DATA_W) and typedef chan_t (CH_W).
  - Function acc_width(DECIM_LOG2).
- One natural sub-module, decim_chan_bank: register file holding acc/cnt/lst for all channels.
  - One read port (combinational by index) and one write port.
  - The top level keeps the handshake and output register.

Test Plan:
- DECIM_LOG2=2, channel 0 samples 1,2,3,6 with m_axis_tready=1 -> a single output tdata=3 (12>>>2), tuser=0, tlast=0, tvalid one cycle after the 4th accept.
- Interleaved channels 0 and 5, 4 samples each: ch0 = 100, ch5 = −100 -> two outputs, tdata=100 tuser=0 and tdata=−100 tuser=5, in completion order.
- Channel 2 samples −1,−1,−1,−2 -> truncate gives −2 (−5>>>2); with DECIM_ROUND_EN gives −1.
- tlast on the 2nd of 4 samples of channel 1 -> output tlast=1; the next window of channel 1 gives tlast=0.
- Hold m_axis_tready=0 with output pending -> s_axis_tready=0, output stable. Release it with a completing input in the same cycle -> back-to-back outputs with no loss.
- Assert s_axis_arst after 3 of 4 samples, then send 4 samples of 8 -> m_axis_tvalid drops immediately; the single output is 8 (the partial sum is discarded).
